// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache.
// Word loads and word/byte stores are served with zero latency on a hit.
// A miss stalls the memory stage while an optional victim writeback and a
// full-line refill run over a line-wide memory port.
//
// Memory handshake: mem_req rises on entry to WRITEBACK or FILL. mem_req,
// mem_we, mem_addr and mem_wdata then hold steady up to and including the
// cycle in which memory returns the one-cycle mem_ack pulse. A mem_ack seen
// in any other state is ignored.
module dcache_ctrl #(
  parameter int ARCH_LEN   = 32,
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic                    req_byte,
  input  logic [ARCH_LEN-1:0]     req_addr,
  input  logic [ARCH_LEN-1:0]     req_wdata,
  output logic [ARCH_LEN-1:0]     rsp_rdata,
  output logic                    stall_out,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ARCH_LEN-1:0]     mem_addr,
  output logic [8*LINE_BYTES-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [8*LINE_BYTES-1:0] mem_rdata,
  output logic [1:0]              dbg_state
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ARCH_LEN - OFF_W - IDX_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int BIT_W  = OFF_W + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic [NUM_LINES-1:0]     valid_q, valid_d;
  logic [NUM_LINES-1:0]     dirty_q, dirty_d;
  // Line address (tag, index) of the miss being resolved.
  logic [TAG_W+IDX_W-1:0]   miss_q, miss_d;
  logic [LINE_W-1:0]        data_q [NUM_LINES];
  logic [LINE_W-1:0]        data_d [NUM_LINES];
  logic [TAG_W-1:0]         tag_q  [NUM_LINES];
  logic [TAG_W-1:0]         tag_d  [NUM_LINES];

  logic [IDX_W-1:0]         req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [OFF_W-1:0]         req_off;
  logic [BIT_W-1:0]         byte_lsb;
  logic [BIT_W-1:0]         word_lsb;
  logic                     hit;
  logic [LINE_W-1:0]        cur_line;
  logic [LINE_W-1:0]        store_line;
  logic [IDX_W-1:0]         miss_idx;
  logic [TAG_W-1:0]         miss_tag;

  assign dbg_state = state_q;
  assign miss_idx  = miss_q[IDX_W-1:0];
  assign miss_tag  = miss_q[TAG_W+IDX_W-1:IDX_W];

  // Address decode, hit detection and the line image after a store merge.
  always_comb begin
    req_off  = req_addr[OFF_W-1:0];
    req_idx  = req_addr[OFF_W +: IDX_W];
    req_tag  = req_addr[ARCH_LEN-1 -: TAG_W];
    byte_lsb = '0;
    byte_lsb[BIT_W-1:3] = req_off;
    word_lsb = '0;
    word_lsb[BIT_W-1:3] = req_off & ~OFF_W'(3);
    hit      = req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    cur_line = data_q[req_idx];
    store_line = cur_line;
    if (req_byte) store_line[byte_lsb +: 8]        = req_wdata[7:0];
    else          store_line[word_lsb +: ARCH_LEN] = req_wdata;
  end

  // Next-state, array updates and all outputs of the miss FSM.
  always_comb begin
    state_d   = state_q;
    miss_d    = miss_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    data_d    = data_q;
    tag_d     = tag_q;
    rsp_rdata = '0;
    stall_out = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            if (req_we) begin
              data_d[req_idx]  = store_line;
              dirty_d[req_idx] = 1'b1;
            end else begin
              rsp_rdata = cur_line[word_lsb +: ARCH_LEN];
            end
          end else begin
            stall_out = 1'b1;
            miss_d    = {req_tag, req_idx};
            state_d   = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        stall_out = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[miss_idx], miss_idx, {OFF_W{1'b0}}};
        mem_wdata = data_q[miss_idx];
        if (mem_ack) begin
          dirty_d[miss_idx] = 1'b0;
          state_d           = FILL;
        end
      end
      FILL: begin
        stall_out = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {miss_tag, miss_idx, {OFF_W{1'b0}}};
        if (mem_ack) begin
          data_d[miss_idx]  = mem_rdata;
          tag_d[miss_idx]   = miss_tag;
          valid_d[miss_idx] = 1'b1;
          dirty_d[miss_idx] = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any miss in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      miss_q  <= miss_d;
    end
  end

  // Data and tag arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache between the memory stage and main memory. It serves word loads and word/byte stores from the memory stage, and it raises the stall that the memory stage forwards backwards on a miss. A miss is resolved by an optional victim writeback followed by a full-line refill over a line-wide memory port.

## Interface
Parameters:
- ARCH_LEN, 32, address/data width.
- LINE_BYTES, 16, bytes per line (power of two, ≥4).
- NUM_LINES, 4, number of lines (power of two).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  memory stage has a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  store width: 1 = byte (addr[1:0] selects lane), 0 = word.
- req_addr  in  ARCH_LEN  byte address; addr[1:0] ignored for words.
- req_wdata  in  ARCH_LEN  store data; byte stores use bits [7:0].
- rsp_rdata  out  ARCH_LEN  load word, valid when req_valid & ~req_we & ~stall_out.
- stall_out  out  1  request not yet served; the memory stage holds its request.
- mem_req  out  1  line transaction pending to main memory.
- mem_we  out  1  1 = line writeback, 0 = line fetch.
- mem_addr  out  ARCH_LEN  line-aligned byte address (low log2(LINE_BYTES) bits zero).
- mem_wdata  out  8*LINE_BYTES  victim line for writeback.
- mem_ack  in  1  one-cycle pulse: transaction complete.
- mem_rdata  in  8*LINE_BYTES  fetched line, valid with mem_ack on fetch.

## Operation
- Address split: offset = addr[log2(LINE_BYTES)-1:0]; index = next log2(NUM_LINES) bits; tag = remaining upper bits (26 bits at defaults).
- Per-line state: valid, dirty, tag, data.
- Hit: req_valid & valid[index] & tag match.
  - Load hit: rsp_rdata = the addressed word, combinational.
  - Store hit: the word or byte is written at the next edge, and dirty[index] is set.
- FSM states: IDLE, WRITEBACK, FILL.
  - IDLE: on req_valid & miss, go to WRITEBACK if valid & dirty, else go to FILL.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line. On mem_ack, go to FILL and clear dirty.
  - FILL: mem_req=1, mem_we=0, mem_addr = request line address. On mem_ack, write mem_rdata into the line, set valid, set tag, clear dirty, and go to IDLE.
- After returning to IDLE, the held request is re-evaluated. It now hits and completes as a normal hit; a store sets dirty.
- stall_out = req_valid & miss in IDLE; it is also 1 for the whole of WRITEBACK and FILL. It is 0 whenever req_valid=0 in IDLE.
- req_* must stay stable while stall_out=1.
  - If req_valid drops during WRITEBACK/FILL (a killed instruction), the transaction still completes and the line is installed.
  - No store is performed for a dropped request; stall_out falls once IDLE is reached.
- mem_req stays high and mem_addr, mem_we and mem_wdata stay stable from state entry until the mem_ack cycle inclusive. mem_ack outside WRITEBACK/FILL is ignored.

## Timing
- Reset (asynchronous, on rst=0):
  - All valid and dirty bits are 0; state = IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, stall_out=0, rsp_rdata=0.
  - Data and tag arrays are not reset.
- Reset mid-miss: the transaction is abandoned immediately and mem_req drops asynchronously. The line is not installed, and a victim being written back is lost.
- Hit latency 0: data returns in the request cycle with no stall.
- Memory latency L ≥ 1 is defined as cycles from the first mem_req cycle to the mem_ack cycle, inclusive.
- Clean miss: the miss is detected in cycle 0 (stall=1). FILL runs in cycles 1..L. The hit is served in cycle L+1 (stall=0). Stall cycles = L+1.
- Dirty miss: WRITEBACK runs in cycles 1..Lw and FILL in cycles Lw+1..Lw+Lf. The hit is served in cycle Lw+Lf+1.
- When mem_ack arrives in WRITEBACK, the next cycle enters FILL with mem_req held high (no idle gap) and mem_we=0.

## Test plan
- Cold load: reset, then load 0x0000_0040 with memory line {0x44,0x33,0x22,0x11,...} and L=3. Required: stall_out is 1 for 4 cycles, no mem_we, mem_addr=0x40, then rsp_rdata=0x1122_3344 with stall 0.
- Store hit then load: word store 0xDEAD_BEEF to 0x44 after the line is resident, then load 0x44. Required: no mem_req, no stall, rsp_rdata=0xDEAD_BEEF.
- Conflict eviction: with dirty line 0x40 resident, load 0x140 (same index, different tag). Required: WRITEBACK to 0x40 with the modified line, then FILL from 0x140, with no idle cycle between.
- Byte store: store byte 0xAA at 0x46 to resident word 0x1122_3344 at 0x44, then load 0x44. Required: rsp_rdata=0x11AA_3344.
- Reset mid-FILL: drop rst during FILL. Required: mem_req=0 immediately; a reload of the same address misses again.
- Killed request: drop req_valid during FILL of a store miss. Required: the line is installed clean, stall_out=0 after mem_ack, and a subsequent load returns the original memory data.
